load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the single-port data memory bus (mem_we/mem_a/mem_wd/mem_rd).
//  Accepts one RV32I load/store request at a time from the execute stage.
//  Sub-word stores are done as read-modify-write on the word-only memory.
//  Returns the aligned, sign/zero-extended load data, or an error for misaligned,
//  out-of-range or illegal requests.
// PARAMETERS
//  MEM_WORDS  64  depth of attached data memory in 32-bit words; word index >= MEM_WORDS -> error
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   LSU idle, can accept; transfer when req_valid & req_ready
//  req_we       in   1   1=store, 0=load
//  req_funct3   in   3   RV32I funct3: LB/LH/LW/LBU/LHU = 000/001/010/100/101; SB/SH/SW = 000/001/010
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data (low byte/half used for SB/SH)
//  resp_valid   out  1   one-cycle completion pulse
//  resp_rdata   out  32  extended load data; 0 for stores and errors
//  resp_err     out  1   valid with resp_valid: misaligned / out-of-range / illegal funct3
//  mem_we       out  1   memory write enable (memory writes on rising clk)
//  mem_a        out  32  memory byte address, always word-aligned ({addr_q[31:2],2'b00})
//  mem_wd       out  32  memory write data
//  mem_rd       in   32  memory read data, combinational from mem_a
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; addr_q, wbuf, resp_rdata=0; resp_valid=0, resp_err=0,
//   mem_we=0, mem_a=0, mem_wd=0, req_ready=1. An in-flight op is abandoned; no write occurs after rst.
//  FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
//  IDLE: req_ready=1. On accept latch we, funct3, addr, wdata. Error check, in priority order:
//   illegal funct3 (load 011/110/111; store >=011) | misaligned (H: a[0]!=0; W: a[1:0]!=0)
//   | addr[31:2] >= MEM_WORDS -> RESP with resp_err=1, no memory write.
//   Otherwise: load -> LOAD; SW -> WRITE with wbuf=wdata; SB/SH -> MERGE.
//  LOAD: mem_a driven; on edge capture lane of mem_rd selected by addr_q[1:0];
//   LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through -> resp_rdata; -> RESP.
//  MERGE: mem_a driven; wbuf = mem_rd with target byte (addr[1:0]) or half (addr[1]) replaced
//   by wdata[7:0] / wdata[15:0]; other lanes preserved bit-exact; -> WRITE.
//  WRITE: mem_we=1, mem_a, mem_wd=wbuf for exactly one cycle; -> RESP.
//  RESP: resp_valid=1 one cycle, resp_err per check, req_ready=0; -> IDLE.
//  req_ready=0 in all non-IDLE states; requests then are ignored (held by requester).
//  Latency accept->resp_valid: error 1, load 2, SW 2, SB/SH 3 cycles. Back-to-back accept
//   possible on the cycle after RESP. mem_we is decoded from state only (glitch-free, never
//   high outside WRITE). mem_a/mem_wd hold last values when idle.
//  Boundary: last word (index MEM_WORDS-1) legal; byte addr 4*MEM_WORDS errors.
//   Store to same word immediately after a load observes prior data; load immediately after
//   store observes new data (write completes before RESP).
// STRUCTURE
//  Shared package/include lsu_defs: funct3 codes (F3_B/H/W/BU/HU), state encodings, error checks.
//  One sub-module: lsu_lane_align (combinational): load extract+extend, store byte/half merge.
//  Top: FSM, request/response registers, memory-bus drive.
// TESTING (bench instantiates data_memory-compatible model, MEM_WORDS=64)
//  SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_we one cycle; resp_rdata=0xDEADBEEF, err=0, latency 2.
//  SB 0xAA @0x11 over 0x11223344 -> word becomes 0x1122AA44; LB @0x11 -> 0xFFFFFFAA; LBU -> 0x000000AA.
//  SH 0x8001 @0x12 over 0x11223344 -> 0x80013344, latency 3; LH @0x12 -> 0xFFFF8001; LHU -> 0x00008001.
//  LW @0x13, LH @0x01, SW @0x100, funct3=011 -> resp_err=1 after 1 cycle, mem_we never asserted.
//  LW @0xFC (word 63) legal; rst asserted during MERGE -> mem_we stays 0, word unchanged, req_ready=1.
//  Back-to-back: req_valid held high with 4 stores -> each accepted cycle after prior RESP, no drops.

Source files
------------

// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding
// and the request legality checks applied at accept time.
package lsu_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } lsu_state_e;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end
        return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_H, F3_HU: bad = a[0];
            F3_W:        bad = (a != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic out_of_range(input logic [31:0] addr, input int unsigned words);
        return ({2'b00, addr[31:2]} >= 32'(words));
    endfunction

    function automatic logic lsu_req_err(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input int unsigned words);
        return f3_illegal(we, f3) || misaligned(f3, addr[1:0]) || out_of_range(addr, words);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load byte/half extraction with extension, and
// store byte/half merge into the word just read back from memory.
module lsu_lane_align
    import lsu_defs::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase
    end

    // Untouched lanes come straight from the read word so they rewrite bit-exact.
    always_comb begin
        merge_data = rdata;
        case (funct3)
            F3_B: merge_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (byte_off[1]) merge_data[31:16] = wdata;
                else             merge_data[15:0]  = wdata;
            end
            default: merge_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit driving a word-wide data memory bus; sub-word
// stores are performed as read-modify-write.
module load_store_unit
    import lsu_defs::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_e  state_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic [31:0] wbuf_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        mem_we_q;

    logic        req_err_d;
    logic [31:0] load_data_d;
    logic [31:0] merge_data_d;

    assign req_err_d = lsu_req_err(req_we, req_funct3, req_addr, MEM_WORDS);

    lsu_lane_align u_lane_align (
        .funct3     (funct3_q),
        .byte_off   (addr_q[1:0]),
        .rdata      (mem_rd),
        .wdata      (wdata_q),
        .load_data  (load_data_d),
        .merge_data (merge_data_d)
    );

    // mem_we_q is set only on entry to WRITE and cleared on every other edge,
    // so it is a flop-driven copy of (state == WRITE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 16'h0;
            wbuf_q       <= 32'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_we_q     <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            mem_we_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q    <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata[15:0];
                        req_ready_q <= 1'b0;
                        if (req_err_d) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else if (!req_we) begin
                            state_q <= S_LOAD;
                        end else if (req_funct3 == F3_W) begin
                            state_q  <= S_WRITE;
                            wbuf_q   <= req_wdata;
                            mem_we_q <= 1'b1;
                        end else begin
                            state_q <= S_MERGE;
                        end
                    end
                end
                S_LOAD: begin
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= load_data_d;
                end
                S_MERGE: begin
                    state_q  <= S_WRITE;
                    wbuf_q   <= merge_data_d;
                    mem_we_q <= 1'b1;
                end
                S_WRITE: begin
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    resp_err_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_we     = mem_we_q;
    assign mem_a      = {addr_q[31:2], 2'b00};
    assign mem_wd     = wbuf_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 64-word behavioural data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [64];
    int checks = 0;
    int errors = 0;
    int we_count = 0;
    int resp_cnt = 0;
    int cyc = 0;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
            we_count <= we_count + 1;
        end
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    // Issues one request from a point 1 ns after an edge; latency counts edges
    // from the accept edge to the first sample with resp_valid high.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er);
        int n;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_a !== 32'h0 || mem_wd !== 32'h0) begin errors++; $display("FAIL reset_bus got a=%h wd=%h exp 0", mem_a, mem_wd); end
        checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got rd=%h err=%b exp 0", resp_rdata, resp_err); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er; int w0;
        w0 = we_count;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er);
        checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp got lat=%0d err=%b rd=%h exp 2 0 0", lat, er, rd); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got %h exp deadbeef", mem[4]); end
        checks++; if (we_count - w0 !== 1) begin errors++; $display("FAIL sw_we_cycles got %0d exp 1", we_count - w0); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
        checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_resp got lat=%0d err=%b rd=%h exp 2 0 deadbeef", lat, er, rd); end
    endtask

    task automatic test_byte();
        int lat; logic [31:0] rd; logic er;
        mem[4] = 32'h11223344;
        do_req(1'b1, 3'b000, 32'h11, 32'hFFFFFFAA, lat, rd, er);
        checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL sb_resp got lat=%0d err=%b exp 3 0", lat, er); end
        checks++; if (mem[4] !== 32'h1122AA44) begin errors++; $display("FAIL sb_mem got %h exp 1122aa44", mem[4]); end
        do_req(1'b0, 3'b000, 32'h11, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hFFFFFFAA || er !== 1'b0) begin errors++; $display("FAIL lb got %h exp ffffffaa", rd); end
        do_req(1'b0, 3'b100, 32'h11, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu got %h exp 000000aa", rd); end
        do_req(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL lb_top got %h exp 00000011", rd); end
    endtask

    task automatic test_half();
        int lat; logic [31:0] rd; logic er;
        mem[4] = 32'h11223344;
        do_req(1'b1, 3'b001, 32'h12, 32'h12348001, lat, rd, er);
        checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL sh_resp got lat=%0d err=%b exp 3 0", lat, er); end
        checks++; if (mem[4] !== 32'h80013344) begin errors++; $display("FAIL sh_mem got %h exp 80013344", mem[4]); end
        do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh got %h exp ffff8001", rd); end
        do_req(1'b0, 3'b101, 32'h12, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu got %h exp 00008001", rd); end
        do_req(1'b0, 3'b001, 32'h10, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h00003344) begin errors++; $display("FAIL lh_low got %h exp 00003344", rd); end
    endtask

    task automatic test_errors();
        logic        we_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3_t [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b011, 3'b000};
        logic [31:0] a_t  [6] = '{32'h13, 32'h01, 32'h100, 32'h10, 32'h10, 32'h100};
        int lat; logic [31:0] rd; logic er; int w0;
        w0 = we_count;
        for (int i = 0; i < 6; i++) begin
            do_req(we_t[i], f3_t[i], a_t[i], 32'h5A5A5A5A, lat, rd, er);
            checks++;
            if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
                errors++;
                $display("FAIL err_case%0d got err=%b lat=%0d rd=%h exp 1 1 0", i, er, lat, rd);
            end
        end
        checks++; if (we_count !== w0) begin errors++; $display("FAIL err_no_write got %0d writes exp 0", we_count - w0); end
    endtask

    task automatic test_boundary();
        int lat; logic [31:0] rd; logic er;
        mem[63] = 32'hCAFEF00D;
        do_req(1'b0, 3'b010, 32'hFC, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL lw_last got rd=%h err=%b lat=%0d exp cafef00d 0 2", rd, er, lat); end
        do_req(1'b0, 3'b000, 32'hFF, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hFFFFFFCA || er !== 1'b0) begin errors++; $display("FAIL lb_last got rd=%h err=%b exp ffffffca 0", rd, er); end
    endtask

    task automatic test_rst_merge();
        int w0; int n;
        mem[5] = 32'h55667788;
        w0 = we_count;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h14; req_wdata = 32'h000000EE;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_merge_outputs got we=%b ready=%b exp 0 1", mem_we, req_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem[5] !== 32'h55667788) begin errors++; $display("FAIL rst_merge_mem got %h exp 55667788", mem[5]); end
        checks++; if (we_count !== w0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_merge_state got writes=%0d ready=%b exp 0 1", we_count - w0, req_ready); end
    endtask

    task automatic test_back_to_back();
        int acc [4]; int w0; int r0; int n;
        w0 = we_count; r0 = resp_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        for (int k = 0; k < 4; k++) begin
            req_addr = 32'h20 + 32'(4 * k);
            req_wdata = 32'hA0000000 + 32'(k);
            n = 0;
            while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            acc[k] = cyc;
        end
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 1; k < 4; k++) begin
            checks++; if (acc[k] - acc[k-1] !== 3) begin errors++; $display("FAIL b2b_spacing%0d got %0d exp 3", k, acc[k] - acc[k-1]); end
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (mem[8 + k] !== 32'hA0000000 + 32'(k)) begin errors++; $display("FAIL b2b_mem%0d got %h exp %h", k, mem[8 + k], 32'hA0000000 + 32'(k)); end
        end
        checks++; if (we_count - w0 !== 4 || resp_cnt - r0 !== 4) begin errors++; $display("FAIL b2b_counts got writes=%0d resps=%0d exp 4 4", we_count - w0, resp_cnt - r0); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_boundary();
        test_rst_merge();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
